// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch front end.
//   fetch_state_e : RUN / HOLD (EXIT fetched, waiting) / HALTED (terminal)
//   NOP_INSTR_C   : bubble encoding (addi x0,x0,0)
//   EXIT_INSTR_C  : finish opcode that stops fetch
//   align_pc()    : clears the two low address bits (word alignment)
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR_C  = 32'h0000_0013;
  localparam logic [31:0] EXIT_INSTR_C = 32'hFFFF_FFFF;

  // Operates on 64 bits so any XLEN up to 64 can truncate the result.
  function automatic logic [63:0] align_pc(input logic [63:0] addr);
    return {addr[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_control_if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
//   clk, rst_n          : clock, synchronous active-low reset
//   load                : capture pc_in/instr_in as a valid instruction
//   bubble              : replace contents with NOP, valid=0, pc=0
//                         (bubble wins over load)
//   pc_in, instr_in     : fetch address and returned instruction word
//   if_id_pc/instr/valid: registered IF/ID contents
// With neither control asserted the register holds.
module if_id_reg #(
  parameter int          XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            bubble,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] instr_in,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_instr,
  output logic            if_id_valid
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (bubble) begin
      // Bubble looks exactly like the reset contents.
      pc_d    = '0;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (load) begin
      pc_d    = pc_in;
      instr_d = instr_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign if_id_pc    = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_valid = valid_q;

endmodule

// File: rtl/fetch_control.sv
// fetch_control: program counter, IF/ID register and EXIT/halt handling.
//   clk, rst_n            : clock, synchronous active-low reset
//   pc_write, if_id_write : hazard-unit advance / IF/ID write enables
//   flush                 : squash IF/ID
//   branch_taken/_target  : redirect from EX (target word-aligned here)
//   instruction           : word fetched from the current pc
//   retire_exit           : EXIT committed in WB -> halt forever
//   pc                    : fetch address
//   if_id_pc/instr/valid  : IF/ID contents for decode
//   halted                : fetch permanently stopped until reset
// Optional macro FETCH_PERF_EN adds saturating fetch_count/stall_count.
// Edge priority: reset > retire_exit > branch_taken > flush > stall > normal.
// A flush in RUN while the EXIT opcode is on the fetch bus holds pc and stays
// in RUN, so the squashed EXIT is simply fetched again.
module fetch_control
  import fetch_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              PC_STEP    = 4,
  parameter logic [XLEN-1:0] NOP_INSTR  = NOP_INSTR_C,
  parameter logic [XLEN-1:0] EXIT_INSTR = EXIT_INSTR_C
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_write,
  input  logic            if_id_write,
  input  logic            flush,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] instruction,
  input  logic            retire_exit,
`ifdef FETCH_PERF_EN
  output logic [31:0]     fetch_count,
  output logic [31:0]     stall_count,
`endif
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_instr,
  output logic            if_id_valid,
  output logic            halted
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            halted_q, halted_d;
  logic            ld, bub;
  logic            adv, is_exit;

  assign adv     = pc_write & if_id_write;
  assign is_exit = (instruction == EXIT_INSTR);

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        fetch_inc, stall_inc;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    ld       = 1'b0;
    bub      = 1'b0;
    if (state_q == ST_HALTED) begin
      // terminal: everything frozen until reset
    end else if (retire_exit) begin
      state_d  = ST_HALTED;
      halted_d = 1'b1;
      bub      = 1'b1;
    end else if (branch_taken) begin
      // Redirect also squashes a wrong-path EXIT sitting in HOLD.
      pc_d    = XLEN'(align_pc(64'(branch_target)));
      bub     = 1'b1;
      state_d = ST_RUN;
    end else if (state_q == ST_HOLD) begin
      if (flush) begin
        bub     = 1'b1;
        state_d = ST_RUN;
      end else if (if_id_write) begin
        bub = 1'b1;
      end
    end else if (flush) begin
      bub = 1'b1;
      if (adv && !is_exit) pc_d = pc_q + XLEN'(PC_STEP);
    end else if (adv) begin
      ld = 1'b1;
      if (is_exit) state_d = ST_HOLD;
      else         pc_d    = pc_q + XLEN'(PC_STEP);
    end else if (if_id_write) begin
      bub = 1'b1;  // pc stalled but IF/ID free: insert bubble
    end
  end

`ifdef FETCH_PERF_EN
  always_comb begin
    fetch_inc   = (state_q == ST_RUN) && ld;
    stall_inc   = (state_q == ST_RUN) && !adv && !branch_taken && !retire_exit;
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (fetch_inc && fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (stall_inc && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (ld),
    .bubble      (bub),
    .pc_in       (pc_q),
    .instr_in    (instruction),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid)
  );

  assign pc     = pc_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_fetch_control.sv
// Bench for fetch_control: directed vector table for the listed scenarios,
// then randomized cycles checked against a behavioural model.
module tb_fetch_control;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] EX  = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n, pc_write, if_id_write, flush, branch_taken, retire_exit;
  logic [31:0] branch_target, instruction;
  logic [31:0] pc, if_id_pc, if_id_instr;
  logic        if_id_valid, halted;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count, stall_count;
`endif

  always #5 clk = ~clk;

  fetch_control dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instruction   (instruction),
    .retire_exit   (retire_exit),
`ifdef FETCH_PERF_EN
    .fetch_count   (fetch_count),
    .stall_count   (stall_count),
`endif
    .pc            (pc),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid),
    .halted        (halted)
  );

  typedef struct {
    logic        rst_n, pw, iw, fl, br;
    logic [31:0] tgt, ins;
    logic        ret;
    logic [31:0] e_pc, e_ifpc, e_ins;
    logic        e_v, e_h;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  // behavioural model state
  logic [31:0] m_pc, m_ifpc, m_ins, m_fc, m_sc;
  logic        m_v, m_h, m_pend;

  function automatic logic [31:0] iw_of(input logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  function automatic vec_t mk(input logic r, pw, iw, fl, br, input logic [31:0] tgt, ins,
                              input logic ret, input logic [31:0] epc, eifpc, eins,
                              input logic ev, eh);
    vec_t v;
    v.rst_n = r; v.pw = pw; v.iw = iw; v.fl = fl; v.br = br; v.tgt = tgt; v.ins = ins;
    v.ret = ret; v.e_pc = epc; v.e_ifpc = eifpc; v.e_ins = eins; v.e_v = ev; v.e_h = eh;
    return v;
  endfunction

  function automatic logic [31:0] sat(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  task automatic m_bubble();
    m_ifpc = 32'd0; m_ins = NOP; m_v = 1'b0;
  endtask

  task automatic model_step(input vec_t v);
    if (!v.rst_n) begin
      m_pc = 32'd0; m_bubble(); m_h = 1'b0; m_pend = 1'b0; m_fc = 32'd0; m_sc = 32'd0;
    end else if (m_h) begin
      // halted: nothing moves
    end else if (v.ret) begin
      m_h = 1'b1; m_bubble();
    end else if (v.br) begin
      m_pc = v.tgt & 32'hFFFF_FFFC; m_bubble(); m_pend = 1'b0;
    end else if (m_pend) begin
      if (v.fl) begin m_bubble(); m_pend = 1'b0; end
      else if (v.iw) m_bubble();
    end else begin
      if (!(v.pw && v.iw)) m_sc = sat(m_sc);
      if (v.fl) begin
        m_bubble();
        if (v.pw && v.iw && v.ins != EX) m_pc = m_pc + 32'd4;
      end else if (v.pw && v.iw) begin
        m_ifpc = m_pc; m_ins = v.ins; m_v = 1'b1; m_fc = sat(m_fc);
        if (v.ins == EX) m_pend = 1'b1;
        else             m_pc = m_pc + 32'd4;
      end else if (v.iw) begin
        m_bubble();
      end
    end
  endtask

  task automatic apply(input vec_t v);
    rst_n = v.rst_n; pc_write = v.pw; if_id_write = v.iw; flush = v.fl;
    branch_taken = v.br; branch_target = v.tgt; instruction = v.ins; retire_exit = v.ret;
    model_step(v);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] epc, eifpc, eins,
                       input logic ev, eh);
    n_vec++;
    if (pc !== epc || if_id_pc !== eifpc || if_id_instr !== eins ||
        if_id_valid !== ev || halted !== eh) begin
      n_err++;
      $display("FAIL %s: got pc=%h ifpc=%h instr=%h v=%b h=%b, want pc=%h ifpc=%h instr=%h v=%b h=%b",
               name, pc, if_id_pc, if_id_instr, if_id_valid, halted, epc, eifpc, eins, ev, eh);
    end
`ifdef FETCH_PERF_EN
    n_vec++;
    if (fetch_count !== m_fc || stall_count !== m_sc) begin
      n_err++;
      $display("FAIL %s perf: got fetch=%0d stall=%0d, want fetch=%0d stall=%0d",
               name, fetch_count, stall_count, m_fc, m_sc);
    end
`endif
  endtask

  initial begin
    // rst pw iw fl br tgt ins ret | pc ifpc instr v h
    tbl.push_back(mk(0,0,0,0,0, 0, 0, 0,             32'h0,  32'h0,  NOP, 0, 0)); // reset
    tbl.push_back(mk(1,1,1,0,0, 0, iw_of(0), 0,      32'h4,  32'h0,  iw_of(0), 1, 0));
    tbl.push_back(mk(1,1,1,0,0, 0, iw_of(4), 0,      32'h8,  32'h4,  iw_of(4), 1, 0));
    tbl.push_back(mk(1,0,0,0,0, 0, iw_of(8), 0,      32'h8,  32'h4,  iw_of(4), 1, 0)); // stall
    tbl.push_back(mk(1,0,0,0,0, 0, iw_of(8), 0,      32'h8,  32'h4,  iw_of(4), 1, 0));
    tbl.push_back(mk(1,0,1,0,0, 0, iw_of(8), 0,      32'h8,  32'h0,  NOP, 0, 0));      // bubble
    tbl.push_back(mk(1,1,1,0,0, 0, iw_of(8), 0,      32'hC,  32'h8,  iw_of(8), 1, 0));
    tbl.push_back(mk(1,1,1,0,1, 32'h26, iw_of(12), 0, 32'h24, 32'h0, NOP, 0, 0));      // redirect
    tbl.push_back(mk(1,1,1,0,0, 0, iw_of(32'h24), 0, 32'h28, 32'h24, iw_of(32'h24), 1, 0));
    tbl.push_back(mk(1,0,1,0,1, 32'hC, iw_of(32'h28), 0, 32'hC, 32'h0, NOP, 0, 0));    // redirect, pc_write=0
    tbl.push_back(mk(1,1,1,0,0, 0, iw_of(12), 0,     32'h10, 32'hC,  iw_of(12), 1, 0));
    tbl.push_back(mk(1,1,1,0,1, 32'h28, iw_of(16), 0, 32'h28, 32'h0, NOP, 0, 0));
    tbl.push_back(mk(1,1,1,0,0, 0, EX, 0,            32'h28, 32'h28, EX, 1, 0));       // EXIT -> HOLD
    tbl.push_back(mk(1,1,0,0,0, 0, EX, 0,            32'h28, 32'h28, EX, 1, 0));
    tbl.push_back(mk(1,1,1,0,1, 32'h8, EX, 0,        32'h8,  32'h0,  NOP, 0, 0));      // wrong-path squash
    tbl.push_back(mk(1,1,1,0,0, 0, iw_of(8), 0,      32'hC,  32'h8,  iw_of(8), 1, 0));
    tbl.push_back(mk(1,1,1,0,1, 32'h28, iw_of(12), 0, 32'h28, 32'h0, NOP, 0, 0));
    tbl.push_back(mk(1,1,1,0,0, 0, EX, 0,            32'h28, 32'h28, EX, 1, 0));
    tbl.push_back(mk(1,1,1,0,0, 0, EX, 0,            32'h28, 32'h0,  NOP, 0, 0));      // HOLD bubble
    tbl.push_back(mk(1,1,1,1,1, 32'h100, EX, 1,      32'h28, 32'h0,  NOP, 0, 1));      // retire wins
    tbl.push_back(mk(1,1,1,1,1, 32'h200, iw_of(0), 0, 32'h28, 32'h0, NOP, 0, 1));      // frozen
    tbl.push_back(mk(1,1,1,0,0, 0, iw_of(0), 1,      32'h28, 32'h0,  NOP, 0, 1));
    tbl.push_back(mk(0,1,1,0,0, 0, iw_of(0), 0,      32'h0,  32'h0,  NOP, 0, 0));      // reset out of HALTED
    tbl.push_back(mk(1,1,1,0,0, 0, iw_of(0), 0,      32'h4,  32'h0,  iw_of(0), 1, 0));
    tbl.push_back(mk(1,1,1,0,1, 32'hFFFF_FFFE, iw_of(4), 0, 32'hFFFF_FFFC, 32'h0, NOP, 0, 0));
    tbl.push_back(mk(1,1,1,0,0, 0, iw_of(32'hFFFF_FFFC), 0, 32'h0, 32'hFFFF_FFFC, iw_of(32'hFFFF_FFFC), 1, 0)); // wrap
    tbl.push_back(mk(1,1,1,1,0, 0, iw_of(0), 0,      32'h4,  32'h0,  NOP, 0, 0));      // flush, pc advances
    tbl.push_back(mk(1,0,0,1,0, 0, iw_of(4), 0,      32'h4,  32'h0,  NOP, 0, 0));      // flush while stalled
    tbl.push_back(mk(1,1,1,0,0, 0, iw_of(4), 0,      32'h8,  32'h4,  iw_of(4), 1, 0));
    tbl.push_back(mk(1,1,1,0,0, 0, EX, 0,            32'h8,  32'h8,  EX, 1, 0));
    tbl.push_back(mk(1,1,1,1,0, 0, EX, 0,            32'h8,  32'h0,  NOP, 0, 0));      // flush in HOLD
    tbl.push_back(mk(1,1,1,0,0, 0, iw_of(8), 0,      32'hC,  32'h8,  iw_of(8), 1, 0)); // back in RUN
    tbl.push_back(mk(1,1,1,0,1, 32'h28, iw_of(12), 0, 32'h28, 32'h0, NOP, 0, 0));
    tbl.push_back(mk(1,1,1,0,0, 0, EX, 0,            32'h28, 32'h28, EX, 1, 0));
    tbl.push_back(mk(0,1,1,0,0, 0, EX, 0,            32'h0,  32'h0,  NOP, 0, 0));      // reset mid-HOLD
    tbl.push_back(mk(1,1,1,0,0, 0, iw_of(0), 0,      32'h4,  32'h0,  iw_of(0), 1, 0)); // RUN after reset
    tbl.push_back(mk(1,1,1,0,0, 0, iw_of(4), 1,      32'h4,  32'h0,  NOP, 0, 1));      // retire in RUN
    tbl.push_back(mk(0,0,0,0,0, 0, 0, 0,             32'h0,  32'h0,  NOP, 0, 0));

    foreach (tbl[i]) begin
      apply(tbl[i]);
      check($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_ifpc, tbl[i].e_ins,
            tbl[i].e_v, tbl[i].e_h);
    end

    // randomized phase against the model
    for (int k = 0; k < 600; k++) begin
      vec_t v;
      v.rst_n = ($urandom_range(0, 59) != 0);
      v.pw    = ($urandom_range(0, 3) != 0);
      v.iw    = ($urandom_range(0, 3) != 0);
      v.fl    = ($urandom_range(0, 9) == 0);
      v.br    = ($urandom_range(0, 7) == 0);
      v.ret   = ($urandom_range(0, 39) == 0);
      v.tgt   = $urandom();
      v.ins   = ($urandom_range(0, 9) == 0) ? EX : $urandom();
      if (v.fl && v.ins == EX) v.ins = NOP;
      apply(v);
      check($sformatf("rnd%0d", k), m_pc, m_ifpc, m_ins, m_v, m_h);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
